// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and transaction types for the data-memory arbiter.
// Used by dmem_arbiter, its interface and the read-data formatter.
package dmem_arbiter_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;
    localparam int WAIT_W     = 4;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_id_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  wen;
        logic                  byt;
        logic [DATA_WIDTH-1:0] wdata;
    } dmem_req_t;

    // Read granted last cycle whose data is coming back from memory now.
    typedef struct packed {
        logic     valid;
        port_id_t port;
        logic     byt;
        logic     lane;
    } pend_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the shared data-memory port.
// Handshake: a requester holds req and its attributes until it sees gnt in the same cycle;
// the gnt cycle carries the transaction, and a granted read returns rvalid exactly one cycle later.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = dmem_arbiter_pkg::ADDR_WIDTH
);
    logic                  m0_req;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic                  m0_wen;
    logic                  m0_byt;
    logic [15:0]           m0_wdata;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [15:0]           m0_rdata;

    logic                  m1_req;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic                  m1_wen;
    logic                  m1_byt;
    logic [15:0]           m1_wdata;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [15:0]           m1_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wen;
    logic                  mem_byt;
    logic [15:0]           mem_wdata;
    logic [15:0]           mem_rdata;

    modport slave (
        input  m0_req, m0_addr, m0_wen, m0_byt, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_addr, m1_wen, m1_byt, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, mem_wen, mem_byt, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_addr, m0_wen, m0_byt, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_addr, m1_wen, m1_byt, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, mem_wen, mem_byt, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_rdata_fmt.sv
// Combinational load formatter: passes a word through, or zero-extends the
// byte lane selected by the low address bit.
module dmem_rdata_fmt
    import dmem_arbiter_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] raw,
    input  logic                  byt,
    input  logic                  lane,
    output logic [DATA_WIDTH-1:0] data
);

    always_comb begin
        data = raw;
        if (byt) begin
            data = {8'h00, (lane ? raw[15:8] : raw[7:0])};
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: CPU priority with a DMA starvation counter,
// or fair round-robin when DMEM_ARB_ROUND_ROBIN_EN is defined.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = dmem_arbiter_pkg::ADDR_WIDTH,
    parameter int MAX_WAIT   = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    dmem_req_t req0;
    dmem_req_t req1;
    dmem_req_t win;
    logic      m1_pref;
    logic      m1_wins;
    logic      gnt0;
    logic      gnt1;

    pend_t           pend_q, pend_d;
    logic [15:0]     rdata0_q, rdata0_d;
    logic [15:0]     rdata1_q, rdata1_d;
    logic            rvalid0;
    logic            rvalid1;
    logic [15:0]     fmt_data;

    always_comb begin
        req0.addr  = bus.m0_addr;
        req0.wen   = bus.m0_wen;
        req0.byt   = bus.m0_byt;
        req0.wdata = bus.m0_wdata;
        req1.addr  = bus.m1_addr;
        req1.wen   = bus.m1_wen;
        req1.byt   = bus.m1_byt;
        req1.wdata = bus.m1_wdata;
    end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_gnt_q, last_gnt_d;

    // Port 1 is favoured whenever port 0 took the most recent grant.
    assign m1_pref = ~last_gnt_q;

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt1) begin
            last_gnt_d = 1'b1;
        end else if (gnt0) begin
            last_gnt_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_q, wait_d;

    assign m1_pref = (wait_q == MAX_WAIT_C);

    always_comb begin
        wait_d = wait_q;
        if (!bus.m1_req || gnt1) begin
            wait_d = '0;
        end else if (wait_q != MAX_WAIT_C) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    // Grants are suppressed while in reset so nothing reaches memory or the pending slot.
    assign m1_wins = bus.m1_req & (~bus.m0_req | m1_pref);
    assign gnt1    = ~rst & m1_wins;
    assign gnt0    = ~rst & bus.m0_req & ~m1_wins;

    always_comb begin
        win = '0;
        if (gnt1) begin
            win = req1;
        end else if (gnt0) begin
            win = req0;
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.mem_addr  = ADDR_WIDTH'(win.addr);
    assign bus.mem_wen   = win.wen;
    assign bus.mem_byt   = win.byt;
    assign bus.mem_wdata = win.wdata;

    always_comb begin
        pend_d.valid = (gnt0 | gnt1) & ~win.wen;
        pend_d.port  = gnt1 ? PORT_DMA : PORT_CPU;
        pend_d.byt   = win.byt;
        pend_d.lane  = win.addr[0];
    end

    dmem_rdata_fmt u_fmt (
        .raw  (bus.mem_rdata),
        .byt  (pend_q.byt),
        .lane (pend_q.lane),
        .data (fmt_data)
    );

    assign rvalid0 = ~rst & pend_q.valid & (pend_q.port == PORT_CPU);
    assign rvalid1 = ~rst & pend_q.valid & (pend_q.port == PORT_DMA);

    // Read data is presented combinationally with rvalid and captured so it holds afterwards.
    always_comb begin
        rdata0_d = rvalid0 ? fmt_data : rdata0_q;
        rdata1_d = rvalid1 ? fmt_data : rdata1_q;
    end

    assign bus.m0_rvalid = rvalid0;
    assign bus.m1_rvalid = rvalid1;
    assign bus.m0_rdata  = rdata0_d;
    assign bus.m1_rdata  = rdata1_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            pend_q   <= pend_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed checks of dmem_arbiter against a cycle-level reference model
// of its arbitration, read-return and reset rules.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int          denied    = 0;
    bit          last_g    = 1'b1;
    bit          pv        = 1'b0;
    bit          pport     = 1'b0;
    bit          pbyt      = 1'b0;
    bit          plane     = 1'b0;
    logic [15:0] held0     = '0;
    logic [15:0] held1     = '0;
    bit          init_done = 1'b0;
    bit          prev_g0   = 1'b0;
    bit          prev_g1   = 1'b0;

    // last sampled DUT outputs, for directed checks
    logic        obs_g0, obs_g1, obs_rv0, obs_rv1, obs_wen;
    logic [15:0] obs_rd0, obs_rd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic dmem_req_t mk(input logic [15:0] a, input logic w, input logic b,
                                     input logic [15:0] d);
        dmem_req_t t;
        t.addr  = a;
        t.wen   = w;
        t.byt   = b;
        t.wdata = d;
        return t;
    endfunction

    function automatic dmem_req_t rnd_req();
        return mk(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom));
    endfunction

    task automatic cycle(input logic r, input logic q0, input dmem_req_t p0,
                         input logic q1, input dmem_req_t p1, input logic [15:0] mrd);
        logic        e0, e1, erv0, erv1, m1_first;
        dmem_req_t   ew;
        logic [15:0] ef, er0, er1;
        rst           = r;
        bus.m0_req    = q0;
        bus.m0_addr   = p0.addr;
        bus.m0_wen    = p0.wen;
        bus.m0_byt    = p0.byt;
        bus.m0_wdata  = p0.wdata;
        bus.m1_req    = q1;
        bus.m1_addr   = p1.addr;
        bus.m1_wen    = p1.wen;
        bus.m1_byt    = p1.byt;
        bus.m1_wdata  = p1.wdata;
        bus.mem_rdata = mrd;
        @(negedge clk);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        m1_first = (last_g == 1'b0);
`else
        m1_first = (denied >= MAX_WAIT);
`endif
        e1   = !r && q1 && (!q0 || m1_first);
        e0   = !r && q0 && !e1;
        ew   = e1 ? p1 : (e0 ? p0 : '0);
        erv0 = !r && pv && !pport;
        erv1 = !r && pv && pport;
        if (!pbyt)      ef = mrd;
        else if (plane) ef = {8'h00, mrd[15:8]};
        else            ef = {8'h00, mrd[7:0]};
        er0 = erv0 ? ef : held0;
        er1 = erv1 ? ef : held1;

        obs_g0  = bus.m0_gnt;
        obs_g1  = bus.m1_gnt;
        obs_rv0 = bus.m0_rvalid;
        obs_rv1 = bus.m1_rvalid;
        obs_rd0 = bus.m0_rdata;
        obs_rd1 = bus.m1_rdata;
        obs_wen = bus.mem_wen;

        chk("m0_gnt", obs_g0, e0);
        chk("m1_gnt", obs_g1, e1);
        chk("mem_addr", bus.mem_addr, ew.addr);
        chk("mem_wen", obs_wen, ew.wen);
        chk("mem_byt", bus.mem_byt, ew.byt);
        chk("mem_wdata", bus.mem_wdata, ew.wdata);
        chk("m0_rvalid", obs_rv0, erv0);
        chk("m1_rvalid", obs_rv1, erv1);
        if (init_done) begin
            chk("m0_rdata", obs_rd0, er0);
            chk("m1_rdata", obs_rd1, er1);
        end

        @(posedge clk);
        if (r) begin
            denied    = 0;
            last_g    = 1'b1;
            pv        = 1'b0;
            held0     = '0;
            held1     = '0;
            init_done = 1'b1;
        end else begin
            if (q1 && !e1) denied = (denied < MAX_WAIT) ? denied + 1 : MAX_WAIT;
            else           denied = 0;
            if (e0) last_g = 1'b0;
            if (e1) last_g = 1'b1;
            if (erv0) held0 = ef;
            if (erv1) held1 = ef;
            pv    = (e0 || e1) && !ew.wen;
            pport = e1;
            pbyt  = ew.byt;
            plane = ew.addr[0];
        end
        prev_g0 = e0;
        prev_g1 = e1;
        #1;
    endtask

    dmem_req_t idle;
    dmem_req_t cp0, cp1;
    logic      cq0, cq1;
    int        exp_win[6];

    initial begin
        idle = mk(16'h0000, 1'b0, 1'b0, 16'h0000);

        // reset with both ports requesting
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, mk(16'h0004, 0, 0, 0), 1'b1, mk(16'h0008, 0, 0, 0), 16'($urandom));
            chk("rst_gnt", {obs_g0, obs_g1}, 0);
            chk("rst_rvalid", {obs_rv0, obs_rv1}, 0);
            chk("rst_wen", obs_wen, 0);
        end
        cycle(1'b0, 1'b1, mk(16'h0004, 0, 0, 0), 1'b1, mk(16'h0008, 0, 0, 0), 16'($urandom));
        chk("first_gnt_p0", obs_g0, 1);
        cycle(1'b0, 1'b0, idle, 1'b1, mk(16'h0008, 0, 0, 0), 16'($urandom));
        cycle(1'b0, 1'b0, idle, 1'b0, idle, 16'($urandom));

        // single word read from port 1
        cycle(1'b0, 1'b0, idle, 1'b1, mk(16'h0102, 0, 0, 0), 16'($urandom));
        chk("single_gnt", obs_g1, 1);
        cycle(1'b0, 1'b0, idle, 1'b0, idle, 16'hBEEF);
        chk("single_rvalid", obs_rv1, 1);
        chk("single_rdata", obs_rd1, 16'hBEEF);
        chk("single_m0_rvalid", obs_rv0, 0);

        // byte reads from port 0, high then low lane
        cycle(1'b0, 1'b1, mk(16'h0103, 0, 1, 0), 1'b0, idle, 16'($urandom));
        cycle(1'b0, 1'b1, mk(16'h0102, 0, 1, 0), 1'b0, idle, 16'h12AB);
        chk("byte_hi", obs_rd0, 16'h0012);
        cycle(1'b0, 1'b0, idle, 1'b0, idle, 16'h12AB);
        chk("byte_lo", obs_rd0, 16'h00AB);
        cycle(1'b0, 1'b0, idle, 1'b0, idle, 16'($urandom));
        chk("rdata_hold", obs_rd0, 16'h00AB);
        chk("hold_rvalid", obs_rv0, 0);

        // contention, starting right after a port-1 grant
        cycle(1'b0, 1'b0, idle, 1'b1, mk(16'h0040, 1, 0, 16'h1234), 16'($urandom));
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp_win = '{0, 1, 0, 1, 0, 1};
`else
        exp_win = '{0, 0, 0, 0, 1, 0};
`endif
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, mk(16'h0200, 0, 0, 0), 1'b1, mk(16'h0300, 0, 0, 0), 16'($urandom));
            chk("contend_g1", obs_g1, exp_win[i]);
            chk("contend_g0", obs_g0, (exp_win[i] == 0));
        end
        cycle(1'b0, 1'b0, idle, 1'b1, mk(16'h0300, 0, 0, 0), 16'($urandom));
        cycle(1'b0, 1'b0, idle, 1'b0, idle, 16'($urandom));

        // back-to-back reads and writes
        cycle(1'b0, 1'b1, mk(16'h0010, 0, 0, 0), 1'b0, idle, 16'($urandom));
        cycle(1'b0, 1'b0, idle, 1'b1, mk(16'h0020, 0, 0, 0), 16'h1111);
        chk("b2b_rv0", obs_rv0, 1);
        chk("b2b_rd0", obs_rd0, 16'h1111);
        chk("b2b_g1", obs_g1, 1);
        cycle(1'b0, 1'b1, mk(16'h0030, 1, 0, 16'h5A5A), 1'b0, idle, 16'h2222);
        chk("b2b_rv1", obs_rv1, 1);
        chk("b2b_rd1", obs_rd1, 16'h2222);
        chk("b2b_wr_wen", obs_wen, 1);
        chk("b2b_wr_no_rv0", obs_rv0, 0);
        cycle(1'b0, 1'b1, mk(16'h0012, 0, 0, 0), 1'b0, idle, 16'($urandom));
        cycle(1'b0, 1'b0, idle, 1'b1, mk(16'h0050, 1, 1, 16'h00C3), 16'h3333);
        chk("b2b_wr2_wen", obs_wen, 1);
        chk("b2b_wr2_rv0", obs_rv0, 1);
        chk("b2b_wr2_rd0", obs_rd0, 16'h3333);
        cycle(1'b0, 1'b0, idle, 1'b0, idle, 16'($urandom));
        chk("write_no_rv1", obs_rv1, 0);

        // reset while a read is in flight, and a read attempted during reset
        cycle(1'b0, 1'b1, mk(16'h0060, 0, 0, 0), 1'b0, idle, 16'($urandom));
        cycle(1'b1, 1'b0, idle, 1'b0, idle, 16'h4444);
        chk("rst_mid_rv0", obs_rv0, 0);
        cycle(1'b0, 1'b0, idle, 1'b0, idle, 16'h5555);
        chk("post_rst_rv0", obs_rv0, 0);
        chk("post_rst_rd0", obs_rd0, 0);
        cycle(1'b1, 1'b1, mk(16'h0070, 0, 0, 0), 1'b0, idle, 16'($urandom));
        chk("rst_read_gnt", obs_g0, 0);
        cycle(1'b0, 1'b0, idle, 1'b0, idle, 16'h6666);
        chk("rst_read_rv0", obs_rv0, 0);

        // randomized traffic obeying the hold-until-grant rule
        cq0 = 1'b0;
        cq1 = 1'b0;
        cp0 = idle;
        cp1 = idle;
        for (int i = 0; i < 400; i++) begin
            if (!cq0 || prev_g0) begin
                cq0 = ($urandom_range(0, 2) != 0);
                cp0 = rnd_req();
            end
            if (!cq1 || prev_g1) begin
                cq1 = ($urandom_range(0, 1) != 0);
                cp1 = rnd_req();
            end
            cycle(($urandom_range(0, 39) == 0), cq0, cp0, cq1, cp1, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
